// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: shared state encoding and width constants for the fetch unit.
//   state_e        : IDLE / FETCH / HALTED controller states
//   INSTR_W        : instruction word width
//   DEFAULT_ADDR_W : default word-address width of instruction memory
package fetch_controller_pkg;
    localparam int INSTR_W        = 32;
    localparam int DEFAULT_ADDR_W = 6;
    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with registered storage and flush.
//   clk, reset : clock, synchronous active-high reset (clears storage too)
//   push_i     : write data_i (caller guarantees room or a same-cycle pop)
//   pop_i      : drop head entry (ignored when empty)
//   flush_i    : discard all entries
//   data_o     : head entry; full_o / empty_o : occupancy flags
module fetch_queue #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, rd_q;
    logic         do_push, do_pop;
    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[PW-1:0]];
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_q[PW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch into a small queue with redirect and halt.
//   clk, reset               : clock, synchronous active-high reset
//   Start, StartAddr         : leave IDLE and fetch from StartAddr
//   Redirect, RedirectAddr   : flush queue and refetch from RedirectAddr (any state)
//   ReadAddress, Instruction : combinational instruction-memory read port
//   InstrValid/Ready/Out/PC  : queue head handshake to decode
//   Halted                   : high while in HALTED
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int QDEPTH       = 2,
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [ADDR_W-1:0]  StartAddr,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectAddr,
    output logic [ADDR_W-1:0]  ReadAddress,
    input  logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               Halted
);
    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          pc_q, pc_d;
    logic [INSTR_W+ADDR_W-1:0]  head;
    logic                       full, empty, pop, fetch, halt_word;
    assign InstrValid  = !empty;
    assign pop         = InstrValid && InstrReady && !Redirect;
    assign halt_word   = HALT_ON_ZERO && (Instruction == '0);
    // Redirect suppresses this cycle's fetch; a full queue fetches only when its head leaves.
    assign fetch       = (state_q == FETCH) && !Redirect && (!full || pop);
    assign ReadAddress = pc_q;
    assign InstrOut    = head[INSTR_W+ADDR_W-1:ADDR_W];
    assign InstrPC     = head[ADDR_W-1:0];
    assign Halted      = state_q == HALTED;
    fetch_queue #(.W(INSTR_W + ADDR_W), .DEPTH(QDEPTH)) u_queue (
        .clk    (clk),
        .reset  (reset),
        .push_i (fetch && !halt_word),
        .pop_i  (pop),
        .flush_i(Redirect),
        .data_i ({Instruction, pc_q}),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (Redirect) begin
            state_d = FETCH;
            pc_d    = RedirectAddr;
        end else if (state_q == IDLE && Start) begin
            state_d = FETCH;
            pc_d    = StartAddr;
        end else if (fetch) begin
            // A halt word is not consumed: PC stays pointing at it.
            state_d = halt_word ? HALTED : FETCH;
            pc_d    = halt_word ? pc_q : pc_q + 1'b1;
        end
    end
endmodule
